// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ requesters.
// Every APB and response output is registered; a hung slave is aborted after TIMEOUT wait cycles.
module apb_master_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        done,
    output logic                      err,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    input  logic                      pready,
    input  logic [DATA_W-1:0]         prdata
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic [NUM_REQ-1:0] cand;
    logic               found;
    logic [IDX_W-1:0]   gnt;
    logic               timeout_hit;
    int                 idx;

    // A requester whose done is high still shows its finished command, so it sits out this cycle.
    always_comb begin
        cand  = req & ~done;
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && cand[idx]) begin
                found = 1'b1;
                gnt   = IDX_W'(idx);
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge pclk) begin
        if (preset) begin
            state    <= IDLE;
            rr_ptr   <= IDX_W'(NUM_REQ - 1);
            gnt_q    <= '0;
            wait_cnt <= '0;
            psel     <= 1'b0;
            penable  <= 1'b0;
            pwrite   <= 1'b0;
            paddr    <= '0;
            pwdata   <= '0;
            done     <= '0;
            err      <= 1'b0;
            rdata    <= '0;
        end else begin
            done  <= '0;
            err   <= 1'b0;
            rdata <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt_q    <= gnt;
                        rr_ptr   <= gnt;
                        wait_cnt <= '0;
                        psel     <= 1'b1;
                        penable  <= 1'b0;
                        pwrite   <= req_write[gnt];
                        paddr    <= req_addr[int'(gnt)*ADDR_W +: ADDR_W];
                        pwdata   <= req_write[gnt] ? req_wdata[int'(gnt)*DATA_W +: DATA_W] : '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel         <= 1'b0;
                        penable      <= 1'b0;
                        done[gnt_q]  <= 1'b1;
                        rdata        <= pwrite ? '0 : prdata;
                        state        <= IDLE;
                    end else if (timeout_hit) begin
                        psel         <= 1'b0;
                        penable      <= 1'b0;
                        done[gnt_q]  <= 1'b1;
                        err          <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares the single APB master port of the matrix-multiplier subsystem between NUM_REQ requesters, for example a host command path and a DMA/sequencer.
- Arbitration is round-robin.
- Sequences each granted command through the APB IDLE -> SETUP -> ACCESS phases and honours pready wait states.
- Returns read data and a completion/error pulse to the winning requester. A timeout aborts a transfer to a hung slave.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 3, APB address width.
- DATA_W, 16, APB data width.
- TIMEOUT, 16, maximum ACCESS cycles without pready before abort. 0 disables the timeout.

Ports:
- pclk  in  1  clock; all logic on the rising edge.
- preset  in  1  synchronous reset, active-high.
- req  in  NUM_REQ  per-requester command valid; held until that requester's done.
- req_write  in  NUM_REQ  per-requester direction (1 = write).
- req_addr  in  NUM_REQ*ADDR_W  per-requester address; slice i = [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  per-requester write data; sliced the same way.
- done  out  NUM_REQ  one-cycle completion pulse, one-hot.
- err  out  1  valid with done; 1 = timeout abort.
- rdata  out  DATA_W  valid with done; captured prdata for reads, 0 for writes and aborts.
- paddr  out  ADDR_W  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_W  APB write data.
- pready  in  1  APB ready.
- prdata  in  DATA_W  APB read data.

Behaviour:
- Reset (preset=1 at a pclk edge): state=IDLE; psel, penable, pwrite, paddr, pwdata, done, err and rdata all 0; rr_ptr=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-transfer: psel and penable are 0 after the reset edge. No done is issued for the aborted command. The requester re-issues it.
- All APB and response outputs are registered.
- FSM state IDLE:
  - Candidates are req bits, excluding any requester whose done is high this cycle (its req is still the old command).
  - If any candidate exists, grant the first one found searching upward from rr_ptr+1 with wrap-around, then set rr_ptr=grant.
  - Latch grant index, write, addr and wdata.
  - Next state is SETUP: psel=1, penable=0, paddr/pwrite from the latch, pwdata = latched wdata for writes and 0 for reads.
  - With no candidate: psel=0, penable=0, paddr/pwrite/pwdata hold their last values.
- FSM state SETUP: exactly one cycle, then ACCESS (penable=1). Address, data and direction are stable from SETUP to end of ACCESS.
- FSM state ACCESS:
  - pready=1 at the edge completes the transfer. Next cycle: psel=0, penable=0, state=IDLE, done[grant]=1, err=0, rdata = prdata sampled at that edge for reads and 0 for writes.
  - pready=0: remain in ACCESS and increment wait_cnt (reset to 0 on SETUP entry).
  - If TIMEOUT!=0 and wait_cnt reaches TIMEOUT-1 with pready=0, abort. Next cycle: psel=0, penable=0, IDLE, done[grant]=1, err=1, rdata=0.
- Throughput: no back-to-back SETUP. Minimum 3 cycles per transfer (SETUP, ACCESS, IDLE/done).
- Latency: req high in IDLE gives psel=1 in the next cycle. Zero-wait transfer gives done 3 cycles after the request edge.
- done, err and rdata are 0 or hold-invalid in all cycles other than the done cycle.
- Requester handshake:
  - The requester must keep req, addr, wdata and write stable until done. Changes while not granted are allowed.
  - In the done cycle the requester either drops req or presents a new command. The new command is eligible from the following IDLE.
- Simultaneous requests: exactly one grant per IDLE. Every requester with req held is served within NUM_REQ transfers.
- Protocol invariants:
  - psel && !penable is followed by psel && penable.
  - psel falls only after penable && pready, on abort, or on reset.
  - paddr, pwrite and pwdata do not change while psel=1.

Test Plan:
- Single write: req[0]=1, write=1, addr=3'h2, wdata=16'hA5A5, pready tied 1. Required: psel at T+1, penable at T+2, done[0] at T+3, err=0, rdata=0, paddr=2 and pwdata=A5A5 throughout.
- Read with 3 wait states: req[1], read addr=5; pready=0 for 3 ACCESS cycles, then 1 with prdata=16'h1234. Required: penable high 4 cycles, done[1]=1, rdata=1234, psel stable throughout.
- Round-robin: NUM_REQ=3, all req held continuously, each requester re-issuing on done. Required: grant order 0,1,2,0,1,2 with no requester served twice before others.
- Timeout: TIMEOUT=16, pready stuck 0. Required: ACCESS lasts 16 cycles, then psel=0, done=1, err=1, rdata=0. Then a fresh request with pready=1 completes normally.
- Reset mid-ACCESS: assert preset during a wait state. Required: psel=penable=0 next cycle, no done pulse, rr_ptr back to NUM_REQ-1, so requester 0 wins next when 0 and 1 request together.
- Done-cycle masking: requester 0 holds req one cycle past done, requester 1 idle. Required: no duplicate transfer starts in the done cycle. The next transfer's SETUP begins one cycle later.
